vip_bit_morph3x3: RTL and testbench

- Parametrised 3x3 binary morphology stage for the edge-detection/gesture pipeline. Placed between the Sobel binariser and the gesture bounding-box stage.
- Replaces the separate fixed erosion and dilation stages with one block. Mode is selectable at run time: bypass, erode, dilate, or majority (rank) filter.
- Image size and frame-stable mode latching are set at build time. Border padding is explicit and depends on the mode.
- Instances can be chained for open/close operations.

---
 rtl/vip_bit_morph3x3.sv | 184 ++++++++++++++++++
 tb/tb_vip_bit_morph3x3.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vip_bit_morph3x3.sv
// rtl/vip_bit_morph3x3.sv - 3x3 binary morphology stage (bypass/erode/dilate/majority), 2-clk latency.
// Optional macro VIP_MORPH_PIXCNT_EN adds frame_ones/frame_ones_vld output-ones counter.
module vip_bit_morph3x3 #(
  parameter int IMG_HDISP = 1024,
  parameter int IMG_VDISP = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  input  logic [1:0]  mode,
  input  logic [3:0]  maj_th,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_bit
`ifdef VIP_MORPH_PIXCNT_EN
  ,
  output logic [21:0] frame_ones,
  output logic        frame_ones_vld
`endif
);

  localparam logic [10:0] COL_MAX = 11'(IMG_HDISP - 1);
  localparam logic [10:0] ROW_MAX = 11'(IMG_VDISP - 1);

  logic        vsync_q, href_q;
  logic        vs_rise, href_fall;
  logic [10:0] col, row;
  logic [1:0]  mode_act, mode_eff;
  logic [3:0]  th_act, th_eff;

  assign vs_rise   = per_frame_vsync & ~vsync_q;
  assign href_fall = href_q & ~per_frame_href;
  // A pixel arriving on the vsync edge must already see the new frame's mode.
  assign mode_eff  = vs_rise ? mode : mode_act;
  assign th_eff    = vs_rise ? maj_th : th_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      col      <= '0;
      row      <= '0;
      mode_act <= 2'b00;
      th_act   <= 4'd9;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (vs_rise) begin
        mode_act <= mode;
        th_act   <= maj_th;
      end
      if (href_fall)
        col <= '0;
      else if (per_frame_clken && col != COL_MAX)
        col <= col + 11'd1;
      if (vs_rise)
        row <= '0;
      else if (href_fall && row != ROW_MAX)
        row <= row + 11'd1;
    end
  end

  // Line buffers and column taps hold don't-care data; the border masks cover them.
  logic [IMG_HDISP-1:0] lb1, lb2;
  logic [2:0]           cur, w1, w2;

  assign cur = {per_img_bit, lb1[IMG_HDISP-1], lb2[IMG_HDISP-1]};

  always_ff @(posedge clk) begin
    if (per_frame_clken) begin
      lb1 <= {lb1[IMG_HDISP-2:0], per_img_bit};
      lb2 <= {lb2[IMG_HDISP-2:0], lb1[IMG_HDISP-1]};
      w1  <= cur;
      w2  <= w1;
    end
  end

  logic [8:0] win_raw, win_m;
  logic [2:0] rmask, cmask;
  logic       pad;

  assign win_raw = {cur, w1, w2};
  assign pad     = (mode_eff == 2'b01);
  assign rmask   = {row <= 11'd1, row == 11'd0, 1'b0};
  assign cmask   = {col <= 11'd1, col == 11'd0, 1'b0};

  // Bit (2-k)*3 + (2-j) holds column c-k, row r-j.
  always_comb begin
    win_m = win_raw;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (rmask[j] || cmask[k])
          win_m[(2-k)*3 + (2-j)] = pad;
      end
    end
  end

  logic [8:0] win_s1;
  logic [1:0] mode_s1;
  logic [3:0] th_s1;
  logic       vsync_s1, href_s1, clken_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_s1   <= '0;
      mode_s1  <= 2'b00;
      th_s1    <= 4'd9;
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      clken_s1 <= 1'b0;
    end else begin
      vsync_s1 <= per_frame_vsync;
      href_s1  <= per_frame_href;
      clken_s1 <= per_frame_clken;
      if (per_frame_clken) begin
        win_s1  <= win_m;
        mode_s1 <= mode_eff;
        th_s1   <= th_eff;
      end
    end
  end

  logic [3:0] ones, th_min;
  logic       res;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 9; i++)
      ones = ones + 4'(win_s1[i]);
    th_min = (th_s1 == 4'd0) ? 4'd1 : th_s1;
    case (mode_s1)
      2'b00:   res = win_s1[4];
      2'b01:   res = &win_s1;
      2'b10:   res = |win_s1;
      default: res = (ones >= th_min);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      post_frame_vsync <= vsync_s1;
      post_frame_href  <= href_s1;
      post_frame_clken <= clken_s1;
      post_img_bit     <= clken_s1 & res;
    end
  end

`ifdef VIP_MORPH_PIXCNT_EN
  logic        post_vs_q, ones_inc;
  logic [21:0] ones_cnt;

  assign ones_inc = post_frame_clken & post_img_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs_q      <= 1'b0;
      ones_cnt       <= '0;
      frame_ones     <= '0;
      frame_ones_vld <= 1'b0;
    end else begin
      post_vs_q      <= post_frame_vsync;
      frame_ones_vld <= 1'b0;
      if (post_frame_vsync && !post_vs_q)
        ones_cnt <= 22'(ones_inc);
      else
        ones_cnt <= ones_cnt + 22'(ones_inc);
      if (!post_frame_vsync && post_vs_q) begin
        frame_ones     <= ones_cnt + 22'(ones_inc);
        frame_ones_vld <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vip_bit_morph3x3.sv
// tb/tb_vip_bit_morph3x3.sv - randomized scoreboard bench for vip_bit_morph3x3 (8x6 image).
// Checks frame_ones too when VIP_MORPH_PIXCNT_EN is defined.
module tb_vip_bit_morph3x3;

  localparam int HD = 8;
  localparam int VD = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit;
  logic [1:0] mode;
  logic [3:0] maj_th;
  logic       post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
`ifdef VIP_MORPH_PIXCNT_EN
  logic [21:0] frame_ones;
  logic        frame_ones_vld;
`endif

  always #5 clk = ~clk;

  vip_bit_morph3x3 #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_bit      (per_img_bit),
    .mode             (mode),
    .maj_th           (maj_th),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_bit     (post_img_bit)
`ifdef VIP_MORPH_PIXCNT_EN
    ,
    .frame_ones       (frame_ones),
    .frame_ones_vld   (frame_ones_vld)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit img [VD][HD];
  bit exp_q [$];
  int ones_q [$];
  logic [2:0] hist0 = 3'b000, hist1 = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference: output (r,c) is the op over input rows r-2..r, cols c-2..c; cells off the top/left take the pad.
  function automatic bit ref_px(int r, int c, logic [1:0] m, int th);
    int pop = 0;
    bit cen = 0;
    bit padv = (m == 2'b01);
    bit v;
    for (int dr = -2; dr <= 0; dr++) begin
      for (int dc = -2; dc <= 0; dc++) begin
        v = (r + dr < 0 || c + dc < 0) ? padv : img[r+dr][c+dc];
        pop += int'(v);
        if (dr == -1 && dc == -1) cen = v;
      end
    end
    case (m)
      2'b00:   return cen;
      2'b01:   return pop == 9;
      2'b10:   return pop > 0;
      default: return pop >= ((th == 0) ? 1 : th);
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {28'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit}, 32'd0);
      exp_q.delete();
      ones_q.delete();
      hist0 = 3'b000;
      hist1 = 3'b000;
    end else begin
      chk("sync_delay2", {29'd0, post_frame_vsync, post_frame_href, post_frame_clken}, {29'd0, hist1});
      if (post_frame_clken) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", 32'd1, 32'd0);
        else chk("pixel", {31'd0, post_img_bit}, {31'd0, exp_q.pop_front()});
      end else begin
        chk("idle_bit_zero", {31'd0, post_img_bit}, 32'd0);
      end
`ifdef VIP_MORPH_PIXCNT_EN
      if (frame_ones_vld) begin
        if (ones_q.size() == 0) chk("unexpected_ones_vld", 32'd1, 32'd0);
        else chk("frame_ones", {10'd0, frame_ones}, ones_q.pop_front());
      end
`endif
      hist1 = hist0;
      hist0 = {per_frame_vsync, per_frame_href, per_frame_clken};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [3:0] th, input bit gaps,
                           input bit mid_chg, input bit do_rst);
    int ones = 0;
    bit e;
    mode = m;
    maj_th = th;
    per_frame_vsync = 1'b1;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < VD; r++) begin
      if (mid_chg && r == 3) begin
        mode = 2'b10;
        maj_th = 4'($urandom);
      end
      for (int c = 0; c < HD; c++) begin
        if (gaps && $urandom_range(1, 0) == 1) begin
          repeat ($urandom_range(2, 1)) begin
            per_frame_href = 1'b1;
            per_frame_clken = 1'b0;
            per_img_bit = 1'($urandom);
            tick();
          end
        end
        per_frame_href = 1'b1;
        per_frame_clken = 1'b1;
        per_img_bit = img[r][c];
        e = ref_px(r, c, m, int'(th));
        exp_q.push_back(e);
        ones += int'(e);
        tick();
        if (do_rst && r == 2 && c == 4) begin
          rst_n = 1'b0;
          per_frame_vsync = 1'b0;
          per_frame_href = 1'b0;
          per_frame_clken = 1'b0;
          per_img_bit = 1'b0;
          repeat (3) tick();
          rst_n = 1'b1;
          repeat (3) tick();
          return;
        end
      end
      per_frame_href = 1'b0;
      per_frame_clken = 1'b0;
      per_img_bit = 1'b0;
      repeat (4) tick();
    end
    ones_q.push_back(ones);
    per_frame_vsync = 1'b0;
    repeat (6) tick();
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < VD; r++)
      for (int c = 0; c < HD; c++)
        case (kind)
          0:       img[r][c] = ((r + c) % 2) == 1;
          1:       img[r][c] = 1'b1;
          2:       img[r][c] = (r == 3 && c == 3);
          3:       img[r][c] = (r >= 2 && r <= 3 && c >= 2 && c <= 3);
          default: img[r][c] = ($urandom_range(99, 0) < 45);
        endcase
  endtask

  task automatic directed_set(input bit gaps);
    fill(0); run_frame(2'b00, 4'd9, gaps, 1'b0, 1'b0);
    fill(1); run_frame(2'b01, 4'd9, gaps, 1'b0, 1'b0);
    fill(2); run_frame(2'b10, 4'd9, gaps, 1'b0, 1'b0);
    fill(3); run_frame(2'b11, 4'd5, gaps, 1'b0, 1'b0);
    fill(3); run_frame(2'b11, 4'd4, gaps, 1'b0, 1'b0);
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    per_img_bit = 1'b0;
    mode = 2'b00;
    maj_th = 4'd9;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    directed_set(1'b0);
    fill(0); run_frame(2'b00, 4'd9, 1'b0, 1'b1, 1'b0);
    run_frame(2'b10, 4'd9, 1'b0, 1'b0, 1'b0);
    directed_set(1'b1);
    for (int i = 0; i < 6; i++) begin
      fill(4);
      run_frame(2'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    fill(4); run_frame(2'b11, 4'd0, 1'b1, 1'b0, 1'b0);
    fill(4); run_frame(2'b11, 4'd12, 1'b0, 1'b0, 1'b0);
    fill(4); run_frame(2'b10, 4'd9, 1'b0, 1'b0, 1'b1);
    fill(4); run_frame(2'b01, 4'd9, 1'b1, 1'b0, 1'b0);

    wait_cyc = 0;
    while ((exp_q.size() != 0 || ones_q.size() != 0) && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    chk("pixels_drained", exp_q.size(), 32'd0);
`ifdef VIP_MORPH_PIXCNT_EN
    chk("ones_drained", ones_q.size(), 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
